spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_gen.sv | 43 ++++
 rtl/spi_master.sv | 113 +++++++++++
 tb/tb_spi_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, default divider, master FSM states.
// Imported by the master RTL and by slave-side benches.
package spi_pkg;

    localparam int FRAME_W         = 16;
    localparam int CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        GAP
    } spi_state_e;

    // Width of a counter that holds 0..clk_div-1 and leaves headroom up to clk_div.
    function automatic int div_cnt_w(input int clk_div);
        return $clog2(clk_div + 1);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: registered sclk level plus one-cycle strobes flagging the clk edge
// on which sclk will rise or fall. Holds sclk low and the count at zero while disabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = en && (div_cnt == CNT_LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= !sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, 16-bit MSB-first frames, SCLK half-period of CLK_DIV clk cycles.
// Optional SPI_MASTER_LOOPBACK_EN: rx shifter samples the internal mosi value instead of miso.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] tx_data,
    output logic [FRAME_W-1:0] rx_data,
    output logic               busy,
    output logic               done,
    output logic               sclk,
    output logic               ss,
    output logic               mosi,
    input  logic               miso
);

    localparam int               CNT_W    = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam int               BIT_W    = $clog2(FRAME_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);

    spi_state_e         state, state_nxt;
    logic [CNT_W-1:0]   phase_cnt;
    logic [BIT_W-1:0]   rise_cnt;
    logic [FRAME_W-1:0] tx_shift;
    logic [FRAME_W-1:0] rx_shift;
    logic               sclk_rise, sclk_fall;
    logic               start_ok, phase_end, in_frame, rx_bit;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == XFER),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // The done cycle is spent in IDLE but must not accept a new frame.
    assign start_ok  = start && (state == IDLE) && !done;
    assign phase_end = (phase_cnt == CNT_LAST);
    assign in_frame  = (state == SETUP) || (state == XFER);

    assign busy = (state != IDLE);
    assign ss   = !in_frame;
    assign mosi = in_frame ? tx_shift[FRAME_W-1] : 1'b0;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = tx_shift[FRAME_W-1];
`else
    assign rx_bit = miso;
`endif

    // NOTE: state_nxt gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = SETUP;
            SETUP:   if (phase_end) state_nxt = XFER;
            XFER:    if (sclk_fall && (rise_cnt == BIT_LAST)) state_nxt = GAP;
            GAP:     if (phase_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            rise_cnt  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == GAP) && (state_nxt == IDLE);

            if ((state_nxt != state) || phase_end) begin
                phase_cnt <= '0;
            end else if ((state == SETUP) || (state == GAP)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            if (start_ok) begin
                tx_shift <= tx_data;
                rise_cnt <= '0;
            end

            if (sclk_rise) begin
                rise_cnt <= rise_cnt + 1'b1;
            end

            // Sample on the falling edge, then present the next tx bit.
            if (sclk_fall) begin
                rx_shift <= {rx_shift[FRAME_W-2:0], rx_bit};
                tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end

            if ((state == GAP) && (state_nxt == IDLE)) begin
                rx_data <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=4 and CLK_DIV=1 instances, each with a mode-0 slave model,
// a table of frames, corner-case sequences, a protocol monitor and an rx scoreboard.
module tb_spi_master;

    typedef struct packed {
        logic [15:0] tx;
        logic [15:0] rx;
    } sb_t;

    typedef struct {
        int          g;
        logic [15:0] tx;
        logic [15:0] sl;
        logic [15:0] exp_rx;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start  [2];
    logic [15:0] tx     [2];
    logic [15:0] rx     [2];
    logic        busy   [2];
    logic        done   [2];
    logic        sclk   [2];
    logic        ss     [2];
    logic        mosi   [2];
    logic        miso   [2];
    logic [15:0] slv_in [2];
    logic [15:0] s_out  [2];

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int rises     [2];
    int ss_hi_run [2];
    int last_gap  [2];
    int done_cnt  [2];
    int frames_exp[2];
    logic        prev_sclk[2];
    logic        prev_mosi[2];
    logic        prev_ss  [2];
    logic [15:0] last_rx  [2];

    sb_t  q0[$];
    sb_t  q1[$];
    sb_t  sb_e;
    int   sb_sz;
    vec_t vecs[5];

    spi_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx[0]), .rx_data(rx[0]),
        .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx[1]), .rx_data(rx[1]),
        .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: loads its word on ss fall, samples mosi and drives the next miso bit on sclk rise.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        logic [15:0] sh_tx = '0;
        logic [15:0] sh_rx = '0;
        logic        miso_q = 1'b0;
        assign miso[g] = miso_q;
        always @(negedge ss[g] or posedge sclk[g]) begin
            if (sclk[g]) begin
                sh_rx  = {sh_rx[14:0], mosi[g]};
                miso_q <= sh_tx[15];
                sh_tx  = {sh_tx[14:0], 1'b0};
            end else begin
                sh_tx = slv_in[g];
                sh_rx = '0;
            end
        end
        always @(posedge ss[g]) s_out[g] = sh_rx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_viol(input int g, input string msg);
        viol++;
        if (viol <= 10) $display("protocol violation dut%0d at %0t: %s", g, $time, msg);
    endtask

    function automatic logic [15:0] exp_rx(input logic [15:0] t, input logic [15:0] s);
`ifdef SPI_MASTER_LOOPBACK_EN
        return t;
`else
        return s;
`endif
    endfunction

    function automatic void push(input int g, input logic [15:0] t, input logic [15:0] r);
        sb_t e;
        e.tx = t;
        e.rx = r;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
        frames_exp[g]++;
    endfunction

    // Protocol checker and scoreboard consumer, sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                last_rx[g] = rx[g];
            end else begin
                if (sclk[g] && prev_sclk[g] && (mosi[g] !== prev_mosi[g])) note_viol(g, "mosi changed while sclk high");
                if (ss[g] && sclk[g])     note_viol(g, "sclk high while ss high");
                if (busy[g] && done[g])   note_viol(g, "busy and done together");
                if (!done[g] && (rx[g] !== last_rx[g])) note_viol(g, "rx_data changed without done");
                if (sclk[g] && !prev_sclk[g]) rises[g]++;
                if (ss[g]) ss_hi_run[g]++;
                if (!ss[g] && prev_ss[g]) begin
                    last_gap[g] = ss_hi_run[g];
                    rises[g]    = 0;
                end
                if (!ss[g]) ss_hi_run[g] = 0;
                if (done[g]) begin
                    done_cnt[g]++;
                    sb_sz = (g == 0) ? q0.size() : q1.size();
                    check($sformatf("sb_entry_dut%0d", g), sb_sz != 0, 1);
                    if (sb_sz != 0) begin
                        if (g == 0) sb_e = q0.pop_front();
                        else        sb_e = q1.pop_front();
                        check($sformatf("rx_data_dut%0d", g), rx[g], sb_e.rx);
                        check($sformatf("slave_out_dut%0d", g), s_out[g], sb_e.tx);
                        check($sformatf("sclk_rises_dut%0d", g), rises[g], 16);
                    end
                end
                last_rx[g] = rx[g];
            end
            prev_sclk[g] = sclk[g];
            prev_mosi[g] = mosi[g];
            prev_ss[g]   = ss[g];
        end
    end

    // One frame: accept, check cycle-1 outputs, count cycles to done. poke>0 pulses a stray start mid-frame.
    task automatic run_frame(input int g, input logic [15:0] t, input logic [15:0] s,
                             input logic [15:0] e_rx, input int e_lat, input int poke);
        int k;
        slv_in[g] = s;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy[g] || done[g]) && k < 300);
        tx[g]    = t;
        start[g] = 1'b1;
        push(g, t, e_rx);
        @(negedge clk);
        start[g] = 1'b0;
        k = 1;
        check($sformatf("cycle1_ss_dut%0d", g), ss[g], 0);
        check($sformatf("cycle1_busy_dut%0d", g), busy[g], 1);
        check($sformatf("cycle1_mosi_dut%0d", g), mosi[g], t[15]);
        while (!done[g] && k < e_lat + 50) begin
            @(negedge clk);
            k++;
            start[g] = (k == poke);
            tx[g]    = (k == poke) ? ~t : t;
        end
        start[g] = 1'b0;
        check($sformatf("done_latency_dut%0d", g), k, e_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int dc;

        vecs[0] = '{0, 16'hA5C3, 16'h3C5A, exp_rx(16'hA5C3, 16'h3C5A), 137};
        vecs[1] = '{0, 16'hBEEF, 16'h0000, exp_rx(16'hBEEF, 16'h0000), 137};
        vecs[2] = '{0, 16'h0001, 16'h8000, exp_rx(16'h0001, 16'h8000), 137};
        vecs[3] = '{1, 16'hFFFF, 16'h5555, exp_rx(16'hFFFF, 16'h5555), 35};
        vecs[4] = '{1, 16'h1234, 16'hEDCB, exp_rx(16'h1234, 16'hEDCB), 35};

        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; tx[g] = '0; slv_in[g] = '0;
            rises[g] = 0; ss_hi_run[g] = 0; last_gap[g] = 0; done_cnt[g] = 0; frames_exp[g] = 0;
            prev_sclk[g] = 1'b0; prev_mosi[g] = 1'b0; prev_ss[g] = 1'b1; last_rx[g] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ss", ss[0], 1);
        check("reset_sclk", sclk[0], 0);
        check("reset_mosi", mosi[0], 0);
        check("reset_busy", busy[0], 0);
        check("reset_done", done[0], 0);
        check("reset_rx", rx[0], 0);
        check("reset_ss_dut1", ss[1], 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].g, vecs[i].tx, vecs[i].sl, vecs[i].exp_rx, vecs[i].exp_lat, -1);

        // Stray start during a frame is ignored: one done only.
        dc = done_cnt[0];
        run_frame(0, 16'h0F0F, 16'hF0F0, exp_rx(16'h0F0F, 16'hF0F0), 137, 10);
        repeat (150) @(negedge clk);
        check("stray_start_one_done", done_cnt[0] - dc, 1);

        // Back-to-back frames at CLK_DIV=1 with start held high.
        slv_in[1] = 16'h8001;
        @(negedge clk);
        tx[1] = 16'hFFFF;
        start[1] = 1'b1;
        push(1, 16'hFFFF, exp_rx(16'hFFFF, 16'h8001));
        k = 0;
        do begin @(negedge clk); k++; end while (!done[1] && k < 200);
        check("b2b_first_done", done[1], 1);
        last_gap[1] = -1;
        tx[1]       = 16'h0000;
        slv_in[1]   = 16'h7FFE;
        push(1, 16'h0000, exp_rx(16'h0000, 16'h7FFE));
        k = 0;
        do begin @(negedge clk); k++; end while (!busy[1] && k < 10);
        check("b2b_second_accept", busy[1], 1);
        start[1] = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!done[1] && k < 200);
        check("b2b_second_done", done[1], 1);
        check("b2b_ss_gap_ge1", last_gap[1] >= 1, 1);

        // Reset in the middle of XFER aborts the frame silently.
        dc = done_cnt[0];
        slv_in[0] = 16'h1111;
        @(negedge clk);
        tx[0] = 16'h5A5A;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        k = 0;
        while (rises[0] != 7 && k < 200) begin @(negedge clk); k++; end
        check("abort_reached_bit7", rises[0], 7);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ss", ss[0], 1);
        check("abort_sclk", sclk[0], 0);
        check("abort_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        check("abort_rx_cleared", rx[0], 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt[0] - dc, 0);
        run_frame(0, 16'h1234, 16'h4321, exp_rx(16'h1234, 16'h4321), 137, -1);

        repeat (5) @(negedge clk);
        check("done_count_dut0", done_cnt[0], frames_exp[0]);
        check("done_count_dut1", done_cnt[1], frames_exp[1]);
        check("sb_drained", q0.size() + q1.size(), 0);
        check("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
